// File: rtl/ifmap_row_tagger_if.sv
// Pixel-in / tagged-word-out bundle for the IFMap row tagger.
// slave = tagger side, master = feeder and IF-buffer side.
interface ifmap_row_tagger_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  buf_ready;
    logic                  buf_wen;
    logic [DATA_WIDTH+1:0] buf_data;

    modport slave (
        input  s_data,
        input  s_valid,
        input  buf_ready,
        output s_ready,
        output buf_wen,
        output buf_data
    );

    modport master (
        output s_data,
        output s_valid,
        output buf_ready,
        input  s_ready,
        input  buf_wen,
        input  buf_data
    );
endinterface

// File: rtl/ifmap_row_tagger.sv
// Frames a pixel stream into rows and writes {tag, pixel}
// words into the conv core's IF buffer through one output register.
module ifmap_row_tagger #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int ROWS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [ROWS_WIDTH-1:0] num_rows,
    ifmap_row_tagger_if.slave     sif,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ROWS_WIDTH-1:0] ROWS_ONE = ROWS_WIDTH'(1);

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  col_q;
    logic [ROWS_WIDTH-1:0] rows_q;
    logic [ROWS_WIDTH-1:0] row_q;
    logic                  wen_q;
    logic                  done_q;
    logic [DATA_WIDTH+1:0] data_q;

    logic                  hs;
    logic                  wr;
    logic                  col_last;
    logic                  row_last;
    logic [1:0]            tag_d;

    // Slot frees when empty or being written this cycle.
    assign sif.s_ready = (state_q == RUN) &&
                         (!wen_q || sif.buf_ready);
    assign hs       = sif.s_valid && sif.s_ready;
    assign wr       = wen_q && sif.buf_ready;
    assign col_last = (col_q == len_q - LEN_ONE);
    assign row_last = (row_q == rows_q - ROWS_ONE);
    assign tag_d    = {col_q == '0, col_last};

    assign sif.buf_wen  = wen_q;
    assign sif.buf_data = data_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            col_q   <= '0;
            rows_q  <= '0;
            row_q   <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (row_len != '0 && num_rows != '0) begin
                            len_q   <= row_len;
                            rows_q  <= num_rows;
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        wen_q  <= 1'b1;
                        data_q <= {tag_d, sif.s_data};
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + ROWS_ONE;
                            if (row_last) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            col_q <= col_q + LEN_ONE;
                        end
                    end else if (wr) begin
                        wen_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!wen_q || sif.buf_ready) begin
                        wen_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
